// File: rtl/fifo_stream_reader_if.sv
// Read-side bundle between a registered-read FIFO, its stream reader and the egress sink.
// master = reader (drives FIFO strobe and stream outputs), slave = FIFO/sink side.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_read_enable;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_read_data_valid;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-2:0] m_data;
  logic                  m_last;

  modport master (
    output fifo_read_enable,
    input  fifo_read_data,
    input  fifo_read_data_valid,
    input  fifo_empty,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  fifo_read_enable,
    output fifo_read_data,
    output fifo_read_data_valid,
    output fifo_empty,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional FIFO_STREAM_READER_STATS_EN adds word_count/packet_count outputs.
//
// state | meaning
// IDLE  | no reads; buffered words still drain to the sink
// RUN   | reads issued while space (count + in-flight) allows
// FLUSH | no reads, no output; buffer cleared once no read is in flight
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  output logic                busy,
`ifdef FIFO_STREAM_READER_STATS_EN
  output logic [31:0]         word_count,
  output logic [31:0]         packet_count,
`endif
  fifo_stream_reader_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [1:0]            count;
  logic                  pending;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] buffer [2];

  logic                  pop;
  logic                  capture;
  logic                  read_enable;
  logic [2:0]            occupancy;

  assign pop       = bus.m_valid && bus.m_ready;
  // Space check counts the word already in flight and credits this cycle's pop.
  assign occupancy = {1'b0, count} + {2'b00, pending} - {2'b00, pop};

  assign read_enable = (state == RUN) && !bus.fifo_empty && !flush
                       && (occupancy < 3'(SKID_DEPTH));
  assign bus.fifo_read_enable = read_enable;

  // read_data_valid is sticky in the FIFO, so only trust it when we asked for data.
  assign capture = pending && bus.fifo_read_data_valid && !flush && (state != FLUSH);

  assign bus.m_valid = (count != 2'd0) && (state != FLUSH);
  assign bus.m_data  = buffer[head][DATA_WIDTH-2:0];
  assign bus.m_last  = buffer[head][DATA_WIDTH-1];
  assign busy        = (state != IDLE) || (count != 2'd0) || pending;

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    if (enable) state_next = RUN;
        RUN:     if (!enable) state_next = IDLE;
        FLUSH:   if (!pending) state_next = enable ? RUN : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 2'd0;
      pending   <= 1'b0;
      head      <= 1'b0;
      tail      <= 1'b0;
      buffer[0] <= '0;
      buffer[1] <= '0;
    end else begin
      state   <= state_next;
      pending <= read_enable;
      if (state == FLUSH && !pending) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else begin
        if (capture) begin
          buffer[tail] <= bus.fifo_read_data;
          tail         <= ~tail;
        end
        if (pop) begin
          head <= ~head;
        end
        count <= count + {1'b0, capture} - {1'b0, pop};
      end
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      word_count   <= 32'd0;
      packet_count <= 32'd0;
    end else if (pop) begin
      word_count <= word_count + 32'd1;
      if (bus.m_last) begin
        packet_count <= packet_count + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      assert (count <= 2'(SKID_DEPTH)) else $error("skid buffer overflow, count=%0d", count);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a small registered-read FIFO model feeds the
// reader; expected words and cycle timing are hand-derived constants.
module tb_fifo_stream_reader;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic flush;
  logic busy;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] word_count;
  logic [31:0] packet_count;
`endif

  fifo_stream_reader_if #(.DATA_WIDTH(16)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(16), .SKID_DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .flush        (flush),
    .busy         (busy),
`ifdef FIFO_STREAM_READER_STATS_EN
    .word_count   (word_count),
    .packet_count (packet_count),
`endif
    .bus          (bus)
  );

  always #5 clock = ~clock;

  // Registered-read FIFO with sticky read-data-valid.
  logic [15:0] mem [64];
  logic [5:0]  wp = 6'd0;
  logic [5:0]  rp = 6'd0;
  logic [15:0] fdata = 16'd0;
  logic        fvalid = 1'b0;
  logic        push_en;
  logic [15:0] push_data;

  assign bus.fifo_empty           = (wp == rp);
  assign bus.fifo_read_data       = fdata;
  assign bus.fifo_read_data_valid = fvalid;

  always @(posedge clock) begin
    if (push_en) begin
      mem[wp] <= push_data;
      wp      <= wp + 6'd1;
    end
    if (bus.fifo_read_enable) begin
      if (wp != rp) begin
        fdata  <= mem[rp];
        fvalid <= 1'b1;
        rp     <= rp + 6'd1;
      end else begin
        fvalid <= 1'b0;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] rx [$];
  logic [15:0] exp2 [8];
  logic [15:0] exp4 [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record popped words, then check the buffer bound and stall stability.
  task automatic tick();
    logic        pv;
    logic        pr;
    logic        pl;
    logic        pf;
    logic [14:0] pd;
    #1;
    pv = bus.m_valid;
    pr = bus.m_ready;
    pd = bus.m_data;
    pl = bus.m_last;
    pf = flush || reset;
    if (pv && pr) rx.push_back({pl, pd});
    @(posedge clock);
    #1;
    chk("count_bound", 32'(dut.count <= 2'd2), 32'd1);
    if (pv && !pr && !pf) begin
      chk("stall_hold", 32'({bus.m_valid, bus.m_last, bus.m_data}), 32'({1'b1, pl, pd}));
    end
  endtask

  task automatic push(input logic [15:0] d);
    push_en   = 1'b1;
    push_data = d;
    tick();
    push_en   = 1'b0;
  endtask

  initial begin
    exp2 = '{16'h0101, 16'h0102, 16'h8103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h8108};
    exp4 = '{16'h0203, 16'h0204, 16'h0205, 16'h0206};
    reset = 1'b1; enable = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
    push_en = 1'b0; push_data = 16'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_rd_en",  32'(bus.fifo_read_enable), 32'd0);
    chk("rst_valid",  32'(bus.m_valid), 32'd0);
    chk("rst_data",   32'(bus.m_data), 32'd0);
    chk("rst_last",   32'(bus.m_last), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);

    // Back-to-back: three preloaded words, ready held high.
    push(16'h0001); push(16'h0002); push(16'h8003);
    rx.delete();
    enable = 1'b1; bus.m_ready = 1'b1;
    #1; chk("b2b_rd_a", 32'(bus.fifo_read_enable), 32'd0); tick();
    #1; chk("b2b_rd_b", 32'(bus.fifo_read_enable), 32'd1);
        chk("b2b_v_b",  32'(bus.m_valid), 32'd0); tick();
    #1; chk("b2b_rd_c", 32'(bus.fifo_read_enable), 32'd1);
        chk("b2b_v_c",  32'(bus.m_valid), 32'd0); tick();
    #1; chk("b2b_rd_d", 32'(bus.fifo_read_enable), 32'd1);
        chk("b2b_w1",   32'({bus.m_valid, bus.m_last, bus.m_data}), 32'h10001); tick();
    #1; chk("b2b_rd_e", 32'(bus.fifo_read_enable), 32'd0);
        chk("b2b_w2",   32'({bus.m_valid, bus.m_last, bus.m_data}), 32'h10002); tick();
    #1; chk("b2b_w3",   32'({bus.m_valid, bus.m_last, bus.m_data}), 32'h18003); tick();
    #1; chk("b2b_done", 32'(bus.m_valid), 32'd0);
        chk("b2b_n",    32'(rx.size()), 32'd3);

    // Empty FIFO with stale sticky valid, then a late word.
    for (int i = 0; i < 5; i++) begin
      #1; chk("empty_rd", 32'(bus.fifo_read_enable), 32'd0);
          chk("empty_v",  32'(bus.m_valid), 32'd0);
      tick();
    end
    push(16'h0042);
    #1; chk("late_rd", 32'(bus.fifo_read_enable), 32'd1);
        chk("late_v0", 32'(bus.m_valid), 32'd0); tick();
    #1; chk("late_v1", 32'(bus.m_valid), 32'd0); tick();
    #1; chk("late_w",  32'({bus.m_valid, bus.m_last, bus.m_data}), 32'h10042); tick();
    #1; chk("late_v3", 32'(bus.m_valid), 32'd0);
        chk("late_rd3", 32'(bus.fifo_read_enable), 32'd0);

    // Eight words (packets of 3 and 5) with ready pattern 1,0,0,1.
    enable = 1'b0; tick();
    for (int i = 0; i < 8; i++) push(exp2[i]);
    rx.delete();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.m_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    bus.m_ready = 1'b1;
    chk("stall_n", 32'(rx.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < rx.size()) chk("stall_word", 32'(rx[i]), 32'(exp2[i]));
    end
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("stats_words", word_count, 32'd12);
    chk("stats_pkts",  packet_count, 32'd3);
`endif

    // Flush with one word buffered and one in flight.
    enable = 1'b0; bus.m_ready = 1'b0; tick();
    for (int i = 1; i <= 6; i++) push(16'h0200 + 16'(i));
    rx.delete();
    enable = 1'b1;
    #1; chk("fl_rd_a", 32'(bus.fifo_read_enable), 32'd0); tick();
    #1; chk("fl_rd_b", 32'(bus.fifo_read_enable), 32'd1); tick();
    #1; chk("fl_rd_c", 32'(bus.fifo_read_enable), 32'd1); tick();
    flush = 1'b1;
    #1; chk("fl_pre",  32'({bus.m_valid, bus.m_last, bus.m_data}), 32'h10201);
        chk("fl_rd_d", 32'(bus.fifo_read_enable), 32'd0); tick();
    flush = 1'b0;
    #1; chk("fl_v",    32'(bus.m_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        chk("fl_rd_e", 32'(bus.fifo_read_enable), 32'd0); tick();
    bus.m_ready = 1'b1;
    #1; chk("fl_count", 32'(dut.count), 32'd0);
        chk("fl_v_f",   32'(bus.m_valid), 32'd0);
        chk("fl_rd_f",  32'(bus.fifo_read_enable), 32'd1);
    repeat (12) tick();
    chk("fl_n", 32'(rx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size()) chk("fl_word", 32'(rx[i]), 32'(exp4[i]));
    end
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("stats_flush_w", word_count, 32'd16);
    chk("stats_flush_p", packet_count, 32'd3);
`endif

    // Reset while a read is in flight; the next cycle's valid must be ignored.
    enable = 1'b0; tick();
    push(16'h0301); push(16'h8302);
    rx.delete();
    enable = 1'b1;
    tick();
    #1; chk("rr_rd_b", 32'(bus.fifo_read_enable), 32'd1); tick();
    reset = 1'b1; enable = 1'b0;
    #1; chk("rr_busy_c", 32'(busy), 32'd1); tick();
    reset = 1'b0;
    #1; chk("rr_v_d",    32'(bus.m_valid), 32'd0);
        chk("rr_rd_d",   32'(bus.fifo_read_enable), 32'd0);
        chk("rr_busy_d", 32'(busy), 32'd0);
        chk("rr_data_d", 32'({bus.m_last, bus.m_data}), 32'd0); tick();
    #1; chk("rr_v_e",    32'(bus.m_valid), 32'd0);
        chk("rr_busy_e", 32'(busy), 32'd0);
        chk("rr_count",  32'(dut.count), 32'd0);
        chk("rr_rx",     32'(rx.size()), 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("rr_stats_w", word_count, 32'd0);
    chk("rr_stats_p", packet_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
